// File: rtl/amber128_slot_sequencer.sv
// Bundle FIFO plus slot/sub12 cursor feeding amber128_decoder.
// Each head bundle is walked S0..S4, with two 12-bit instructions in a slot when its flag is set.
package amber128_pkg;
  typedef struct packed {
    logic         valid;
    logic [31:0]  word_addr;
    logic [127:0] bundle;
  } amber128_fetch_s;
endpackage

module amber128_slot_sequencer
  import amber128_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  amber128_fetch_s fetch_i,
  output logic            fetch_ready_o,
  input  logic            flush_i,
  output amber128_fetch_s issue_o,
  output logic [2:0]      slot_idx_o,
  output logic            sub12_o,
  output logic            last_o,
  input  logic            issue_ready_i,
  output logic [31:0]     issued_cnt_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]  word_addr;
    logic [127:0] bundle;
  } entry_t;

  typedef enum logic {EMPTY, ISSUE} state_e;

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  state_e      state;
  logic [2:0]  slot;
  logic        sub;
  logic [4:0]  flags;
  logic        full, valid, hs, two12_cur, last, push, pop;
  entry_t      head;

  assign head  = mem[rd_ptr[AW-1:0]];
  assign flags = head.bundle[127:123];
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = (state == ISSUE);

  always_comb begin
    two12_cur = 1'b0;
    case (slot)
      3'd0: two12_cur = flags[4];
      3'd1: two12_cur = flags[3];
      3'd2: two12_cur = flags[2];
      3'd3: two12_cur = flags[1];
      3'd4: two12_cur = flags[0];
      default: two12_cur = 1'b0;
    endcase
  end

  // Ready looks only at registered occupancy, so a pop never opens space in the same cycle.
  assign fetch_ready_o = !full && !flush_i;
  assign push          = fetch_i.valid && fetch_ready_o;
  assign hs            = valid && issue_ready_i;
  assign last          = valid && (slot == 3'd4) && (!two12_cur || sub);
  assign pop           = hs && last;

  assign wr_nxt = flush_i ? '0 : wr_ptr + (AW+1)'(push);
  assign rd_nxt = flush_i ? '0 : rd_ptr + (AW+1)'(pop);

  assign issue_o      = valid ? {1'b1, head.word_addr, head.bundle} : '0;
  assign slot_idx_o   = slot;
  assign sub12_o      = sub;
  assign last_o       = last;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{word_addr: fetch_i.word_addr, bundle: fetch_i.bundle};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      state        <= EMPTY;
      slot         <= '0;
      sub          <= 1'b0;
      issued_cnt_o <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      state  <= (wr_nxt != rd_nxt) ? ISSUE : EMPTY;
      if (hs) issued_cnt_o <= issued_cnt_o + 32'd1;
      if (flush_i || pop) begin
        slot <= '0;
        sub  <= 1'b0;
      end else if (hs) begin
        if (two12_cur && !sub) begin
          sub <= 1'b1;
        end else begin
          slot <= slot + 3'd1;
          sub  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_amber128_slot_sequencer.sv
// Directed scenarios plus random traffic, checked every cycle against a bundle-queue model.
module tb_amber128_slot_sequencer;
  import amber128_pkg::*;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  amber128_fetch_s fetch;
  logic            flush, ready;
  logic            fetch_ready, sub12, last;
  amber128_fetch_s issue;
  logic [2:0]      slot_idx;
  logic [31:0]     cnt;

  amber128_slot_sequencer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_i(fetch), .fetch_ready_o(fetch_ready),
    .flush_i(flush), .issue_o(issue), .slot_idx_o(slot_idx), .sub12_o(sub12),
    .last_o(last), .issue_ready_i(ready), .issued_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [127:0] b;} ment_t;
  ment_t       mq[$];
  int          idx;
  int unsigned mcnt;
  logic [3:0]  hslog[$];
  int          n_cmp = 0, n_bad = 0;

  function automatic int ninstr(logic [127:0] b);
    int n = 0;
    for (int s = 0; s < 5; s++) n += b[127-s] ? 2 : 1;
    return n;
  endfunction

  function automatic void locate(logic [127:0] b, int k, output int slot, output int sub);
    slot = 0; sub = 0;
    for (int s = 0; s < 5; s++) begin
      int w = b[127-s] ? 2 : 1;
      if (k < w) begin slot = s; sub = k; return; end
      k -= w;
    end
  endfunction

  function automatic logic [127:0] mk(logic [4:0] flags);
    return {flags, 3'($urandom), $urandom, $urandom, $urandom, 24'($urandom)};
  endfunction

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic compare();
    int s, u;
    chk("valid", issue.valid, mq.size() > 0);
    chk("fetch_ready", fetch_ready, (mq.size() < DEPTH) && !flush);
    chk("issued_cnt", cnt, mcnt);
    if (mq.size() > 0) begin
      locate(mq[0].b, idx, s, u);
      chk("word_addr", issue.word_addr, mq[0].a);
      chk("bundle", issue.bundle, mq[0].b);
      chk("slot_idx", slot_idx, s);
      chk("sub12", sub12, u);
      chk("last", last, idx == ninstr(mq[0].b) - 1);
    end else begin
      chk("last_idle", last, 1'b0);
    end
    if (issue.valid && ready) hslog.push_back({slot_idx, sub12});
  endtask

  task automatic step();
    int  sz = mq.size();
    bit  hs = (sz > 0) && ready;
    if (hs) mcnt++;
    if (flush) begin
      mq.delete();
      idx = 0;
    end else begin
      if (hs) begin
        idx++;
        if (idx == ninstr(mq[0].b)) begin
          void'(mq.pop_front());
          idx = 0;
        end
      end
      if (fetch.valid && sz < DEPTH) mq.push_back('{a: fetch.word_addr, b: fetch.bundle});
    end
  endtask

  task automatic cyc(bit fv, logic [127:0] b, logic [31:0] a, bit fl, bit rd);
    fetch.valid = fv; fetch.bundle = b; fetch.word_addr = a;
    flush = fl; ready = rd;
    @(negedge clk) compare();
    @(posedge clk) step();
    #1;
  endtask

  task automatic idle(int n, bit rd);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, rd);
  endtask

  task automatic chk_log(string nm, logic [3:0] exp[$]);
    chk({nm, "_len"}, hslog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < hslog.size(); i++) chk(nm, hslog[i], exp[i]);
    hslog.delete();
  endtask

  initial begin
    fetch = '0; flush = 0; ready = 0;
    idx = 0; mcnt = 0;
    #12;
    chk("rst_valid", issue.valid, 1'b0);
    chk("rst_issue", issue, '0);
    chk("rst_fetch_ready", fetch_ready, 1'b1);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_last", last, 1'b0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: all single slots
    cyc(1, mk(5'h00), 32'h100, 0, 1);
    idle(6, 1);
    chk_log("t1_seq", '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8});
    chk("t1_cnt", cnt, 32'd5);

    // 2: mixed flags
    cyc(1, mk(5'b10100), 32'h200, 0, 1);
    idle(8, 1);
    chk_log("t2_seq", '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8});
    chk("t2_cnt", cnt, 32'd12);

    // 3: back-to-back, FIFO fills
    cyc(1, mk(5'h1F), 32'h300, 0, 1);
    cyc(1, mk(5'h00), 32'h304, 0, 1);
    idle(16, 1);
    chk("t3_len", hslog.size(), 15);
    hslog.delete();
    chk("t3_cnt", cnt, 32'd27);

    // 4: stall at (2,1)
    cyc(1, mk(5'b10100), 32'h400, 0, 1);
    idle(4, 1);
    idle(3, 0);
    chk("t4_stall_slot", slot_idx, 3'd2);
    chk("t4_stall_sub", sub12, 1'b1);
    chk("t4_stall_cnt", cnt, 32'd31);
    idle(4, 1);
    chk_log("t4_seq", '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8});

    // 5: flush at (1,0) with second queued and third pushed
    cyc(1, mk(5'h00), 32'h500, 0, 1);
    cyc(1, mk(5'h00), 32'h504, 0, 1);
    cyc(1, mk(5'h00), 32'h508, 1, 1);
    chk("t5_valid", issue.valid, 1'b0);
    idle(1, 1);
    chk("t5_cnt", cnt, 32'd36);
    hslog.delete();
    cyc(1, mk(5'h1F), 32'h50C, 0, 1);
    idle(11, 1);
    chk("t5_first", hslog.size() > 0 ? hslog[0] : 4'hF, 4'h0);
    chk("t5_cnt2", cnt, 32'd46);
    hslog.delete();

    // 6: async reset at slot 3
    cyc(1, mk(5'h00), 32'h600, 0, 1);
    idle(3, 1);
    chk("t6_pre_slot", slot_idx, 3'd3);
    fetch = '0; ready = 1;
    rst_n = 0;
    #1;
    chk("t6_valid", issue.valid, 1'b0);
    chk("t6_issue", issue, '0);
    chk("t6_slot", slot_idx, 3'd0);
    chk("t6_last", last, 1'b0);
    chk("t6_cnt", cnt, 32'd0);
    chk("t6_fready", fetch_ready, 1'b1);
    mq.delete(); idx = 0; mcnt = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    idle(1, 1);
    hslog.delete();

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 1), mk(5'($urandom)), $urandom, $urandom_range(0, 31) == 0,
          $urandom_range(0, 3) != 0);
    idle(25, 1);
    chk("rand_drained", issue.valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
